// File: rtl/ahb_fifo_pkg.sv
// Shared definitions for the AHB-Lite to FIFO write bridge: bus encodings,
// FSM states and status word layout.
package ahb_fifo_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    RDATA,
    ERR1,
    ERR2
  } state_e;

  localparam int FULL_LSB = 0;
  localparam int DROP_LSB = 16;

endpackage

// File: rtl/ahb_fifo_bridge_if.sv
// AHB-Lite slave bus plus the FIFO write side of the bridge, grouped as one
// interface; the bridge uses the slave view, the bus master/FIFOs the master view.
interface ahb_fifo_bridge_if #(
  parameter int DATA_W = 32,
  parameter int NCH    = 4
);
  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [31:0]       HADDR;
  logic [31:0]       HWDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [NCH-1:0]    wfull;
  logic [NCH-1:0]    winc;
  logic [DATA_W-1:0] wdata;

  modport slave (
    input  HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, wfull,
    output HREADYOUT, HRESP, HRDATA, winc, wdata
  );

  modport master (
    output HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, wfull,
    input  HREADYOUT, HRESP, HRDATA, winc, wdata
  );
endinterface

// File: rtl/ahb_fifo_decode.sv
// Word-index decode: channel one-hot, status-word select, and invalid flag
// for any index beyond the status word.
module ahb_fifo_decode
  import ahb_fifo_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH + 1)
) (
  input  logic [IW-1:0]  idx_i,
  output logic [NCH-1:0] ch_oh_o,
  output logic           stat_o,
  output logic           inval_o
);
  always_comb begin
    ch_oh_o = '0;
    for (int i = 0; i < NCH; i++) ch_oh_o[i] = (idx_i == IW'(i));
  end

  assign stat_o  = (idx_i == IW'(NCH));
  assign inval_o = ~stat_o & ~|ch_oh_o;
endmodule

// File: rtl/ahb_fifo_bridge.sv
// AHB-Lite slave turning bus writes into per-channel FIFO write strobes, with
// a W1C status word and a stall timeout that answers ERROR on a stuck FIFO.
module ahb_fifo_bridge
  import ahb_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NCH      = 4,
  parameter int TIMEOUT  = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic             clk,
  input  logic             rst,
  ahb_fifo_bridge_if.slave bus
);
  localparam int IW = $clog2(NCH + 1);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [NCH-1:0] drop_q, drop_d;
  logic [NCH-1:0] ch_q;
  logic           stat_q;
  logic           resp_q;

  logic [NCH-1:0] dec_ch;
  logic           dec_stat, dec_inval;
  logic           sample, stall, tmo, advance;
  state_e         dp_state;
  logic [31:0]    status;
  logic           unused_bits;

  ahb_fifo_decode #(.NCH(NCH), .IW(IW)) u_decode (
    .idx_i   (bus.HADDR[ADDR_LSB +: IW]),
    .ch_oh_o (dec_ch),
    .stat_o  (dec_stat),
    .inval_o (dec_inval)
  );

  assign sample  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign stall   = (state_q == WDATA) && |(ch_q & bus.wfull);
  assign tmo     = stall && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  // Any cycle that completes a data phase (or idles) may accept the next address.
  assign advance = (state_q == IDLE) ||
                   ((state_q inside {WDATA, RDATA, ERR2}) && !stall);

  always_comb begin
    dp_state = IDLE;
    if (sample) begin
      if (dec_inval)       dp_state = ERR1;
      else if (bus.HWRITE) dp_state = WDATA;
      else                 dp_state = RDATA;
    end
  end

  // Clear first, then set, so a simultaneous drop event wins over W1C.
  always_comb begin
    drop_d = drop_q;
    if (state_q == WDATA && stat_q) drop_d = drop_d & ~bus.HWDATA[DROP_LSB +: NCH];
    if (tmo) drop_d = drop_d | ch_q;
  end

  always_comb begin
    status = '0;
    status[FULL_LSB +: NCH] = bus.wfull;
    status[DROP_LSB +: NCH] = drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= '0;
      resp_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      resp_q <= 1'b0;
      if (advance) begin
        state_q <= dp_state;
        cnt_q   <= '0;
        ch_q    <= dec_ch;
        stat_q  <= dec_stat;
        resp_q  <= (dp_state == ERR1);
      end else if (state_q == ERR1) begin
        state_q <= ERR2;
        resp_q  <= 1'b1;
      end else if (tmo) begin
        state_q <= ERR1;
        resp_q  <= 1'b1;
      end else if (stall && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.HREADYOUT = rst | ~((state_q == ERR1) | stall);
  assign bus.HRESP     = ~rst & resp_q;
  assign bus.winc      = (!rst && state_q == WDATA && !stall) ? ch_q : '0;
  assign bus.HRDATA    = (!rst && state_q == RDATA && stat_q) ? status : '0;
  assign bus.wdata     = bus.HWDATA[DATA_W-1:0];
  assign unused_bits   = ^{bus.HTRANS[0], bus.HADDR, bus.HWDATA};
endmodule

// File: tb/tb_ahb_fifo_bridge.sv
// Randomized and directed bench for ahb_fifo_bridge against a transfer-level
// reference model of the bus protocol, FIFO strobes and status word.
module tb_ahb_fifo_bridge;
  import ahb_fifo_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NCH      = 4;
  localparam int TIMEOUT  = 4;
  localparam int ADDR_LSB = 2;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_fifo_bridge_if #(.DATA_W(DATA_W), .NCH(NCH)) ahb ();
  assign ahb.HREADY = ahb.HREADYOUT;

  ahb_fifo_bridge #(
    .DATA_W(DATA_W), .NCH(NCH), .TIMEOUT(TIMEOUT), .ADDR_LSB(ADDR_LSB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ahb)
  );

  req_t           req_q[$];
  bit             ap_v, dp_v;
  req_t           ap, dp;
  int             dp_err;
  int             dp_stall;
  logic [NCH-1:0] drop_m;
  int             n_chk, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input int idx, input bit wr, input logic [31:0] data);
    req_t r;
    r.idx  = idx;
    r.wr   = wr;
    r.data = data;
    r.addr = $urandom;
    r.addr[ADDR_LSB +: 3] = 3'(idx);
    req_q.push_back(r);
  endtask

  // One bus cycle: drive, check this cycle's outputs, then advance the model.
  task automatic step(input logic [NCH-1:0] wf);
    logic           rdy_e, resp_e;
    logic [NCH-1:0] winc_e;
    logic [31:0]    rd_e;
    @(negedge clk);
    rst = 1'b0;
    if (!ap_v && req_q.size() > 0) begin
      ap   = req_q.pop_front();
      ap_v = 1'b1;
    end
    ahb.wfull = wf;
    if (ap_v) begin
      ahb.HSEL   = 1'b1;
      ahb.HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
      ahb.HADDR  = ap.addr;
      ahb.HWRITE = ap.wr;
    end else begin
      ahb.HADDR  = $urandom;
      ahb.HWRITE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) begin
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'($urandom_range(0, 3));
      end else begin
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_BUSY : HTRANS_IDLE;
      end
    end
    ahb.HWDATA = dp_v ? dp.data : $urandom;
    #1;

    rdy_e  = 1'b1;
    resp_e = 1'b0;
    winc_e = '0;
    rd_e   = '0;
    if (dp_v) begin
      if (dp_err == 1) begin
        rdy_e  = 1'b0;
        resp_e = 1'b1;
      end else if (dp_err == 2) begin
        resp_e = 1'b1;
      end else if (dp.wr && dp.idx < NCH) begin
        if (wf[dp.idx]) rdy_e = 1'b0;
        else            winc_e[dp.idx] = 1'b1;
      end else if (!dp.wr && dp.idx == NCH) begin
        rd_e[NCH-1:0]     = wf;
        rd_e[16 +: NCH]   = drop_m;
      end
    end

    check_eq("hreadyout", 32'(ahb.HREADYOUT), 32'(rdy_e));
    check_eq("hresp", 32'(ahb.HRESP), 32'(resp_e));
    check_eq("winc", 32'(ahb.winc), 32'(winc_e));
    check_eq("hrdata", ahb.HRDATA, rd_e);
    if (winc_e != '0) check_eq("wdata", 32'(ahb.wdata), 32'(dp.data[DATA_W-1:0]));

    if (dp_v && dp_err == 0 && dp.wr && dp.idx < NCH && wf[dp.idx]) begin
      if (TIMEOUT != 0 && dp_stall == TIMEOUT - 1) begin
        dp_err = 1;
        drop_m[dp.idx] = 1'b1;
      end else begin
        dp_stall++;
      end
    end else if (dp_v && dp_err == 1) begin
      dp_err = 2;
    end else begin
      if (dp_v && dp_err == 0 && dp.wr && dp.idx == NCH) drop_m &= ~dp.data[16 +: NCH];
      dp_v     = ap_v;
      dp       = ap;
      dp_err   = (ap_v && ap.idx > NCH) ? 1 : 0;
      dp_stall = 0;
      ap_v     = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = HTRANS_IDLE;
    ahb.wfull  = NCH'($urandom);
    #1;
    check_eq("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
    check_eq("rst_hresp", 32'(ahb.HRESP), 32'd0);
    check_eq("rst_winc", 32'(ahb.winc), 32'd0);
    dp_v   = 1'b0;
    ap_v   = 1'b0;
    dp_err = 0;
    drop_m = '0;
  endtask

  initial begin
    logic [NCH-1:0] wf;
    n_chk      = 0;
    n_err      = 0;
    ap_v       = 1'b0;
    dp_v       = 1'b0;
    dp_err     = 0;
    dp_stall   = 0;
    drop_m     = '0;
    ahb.HSEL   = 1'b0;
    ahb.HWRITE = 1'b0;
    ahb.HTRANS = HTRANS_IDLE;
    ahb.HADDR  = '0;
    ahb.HWDATA = '0;
    ahb.wfull  = '0;

    do_reset();
    do_reset();

    // single write to channel 2
    push_req(2, 1'b1, 32'h1234_00A5);
    repeat (3) step('0);

    // back-to-back writes to every channel
    for (int i = 0; i < NCH; i++) push_req(i, 1'b1, $urandom);
    repeat (6) step('0);

    // short stall on channel 1, then completion
    push_req(1, 1'b1, $urandom);
    step('0);
    repeat (3) step(4'b0010);
    repeat (2) step('0);

    // channel 3 stuck full: timeout, error, then status read
    push_req(3, 1'b1, $urandom);
    step('0);
    repeat (7) step(4'b1000);
    push_req(NCH, 1'b0, $urandom);
    repeat (3) step(4'b1000);

    // clear drop[3] via status W1C, then an invalid index, then re-read status
    push_req(NCH, 1'b1, 32'h0008_0000);
    repeat (3) step('0);
    push_req(5, 1'b1, $urandom);
    repeat (4) step('0);
    push_req(NCH, 1'b0, $urandom);
    repeat (3) step('0);

    // reset in the middle of a stall, after an earlier drop
    push_req(2, 1'b1, $urandom);
    step('0);
    repeat (5) step(4'b0100);
    push_req(0, 1'b1, $urandom);
    step('0);
    repeat (2) step(4'b0001);
    do_reset();
    push_req(NCH, 1'b0, $urandom);
    repeat (3) step('0);

    // randomized traffic with slowly toggling full flags
    wf = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 7) == 0) wf[k] = ~wf[k];
      if (req_q.size() == 0 && $urandom_range(0, 2) != 0)
        push_req($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(wf);
    end
    repeat (12) step('0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
